// File: rtl/vga_pkg.sv
// Shared raster timing definitions: 640x480 defaults, totals helpers and the
// coordinate width used by every position counter and output.
package vga_pkg;

    localparam int COORD_W   = 11;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLKDIV   = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_prescaler.sv
// Divides the system clock down to a one-clk pixel strobe every CLKDIV clks.
module pix_prescaler #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // With CLKDIV == 1 div stays at 0 == DIV_LAST, so the strobe is constant.
    assign tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: position counters advanced on the pixel strobe,
// with every sync/enable/coordinate/marker output registered from them.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   CLKDIV   = DEF_CLKDIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pxen,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sof,
    output logic               eol
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t H_SYNC_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t V_SYNC_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_check
        $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
    end
    if (CLKDIV < 1) begin : g_clkdiv_check
        $error("vga_timing: CLKDIV must be at least 1");
    end

    logic   tick;
    coord_t hcnt_q, hcnt_d;
    coord_t vcnt_q, vcnt_d;
    logic   first_q;
    logic   pxen_q;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   de_q, de_d;
    coord_t x_q, y_q;
    logic   sof_q, sof_d;
    logic   eol_q, eol_d;
    logic   fresh;

    pix_prescaler #(
        .CLKDIV(CLKDIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick_o(tick)
    );

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + coord_t'(1);
            end else begin
                hcnt_d = hcnt_q + coord_t'(1);
            end
        end
    end

    // A position is new to the outputs in the clk after a counter advance, or
    // in the very first clk after reset; markers fire only then.
    assign fresh = pxen_q || first_q;

    always_comb begin
        de_d    = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
        hsync_d = ((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vsync_d = ((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
        sof_d   = fresh && (hcnt_q == '0) && (vcnt_q == '0);
        eol_d   = fresh && (hcnt_q == H_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            first_q <= 1'b1;
            pxen_q  <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            first_q <= 1'b0;
            pxen_q  <= tick;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= hcnt_q;
            y_q     <= vcnt_q;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign pxen  = pxen_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign x     = x_q;
    assign y     = y_q;
    assign sof   = sof_q;
    assign eol   = eol_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three geometries checked clk-by-clk against a
// closed-form raster model through a scoreboard, plus directed timing checks.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        pxen_def, hsync_def, vsync_def, de_def, sof_def, eol_def;
    logic [10:0] x_def, y_def;
    logic        pxen_sml, hsync_sml, vsync_sml, de_sml, sof_sml, eol_sml;
    logic [10:0] x_sml, y_sml;
    logic        pxen_med, hsync_med, vsync_med, de_med, sof_med, eol_med;
    logic [10:0] x_med, y_med;

    vga_timing u_def (
        .clk(clk), .rst(rst), .pxen(pxen_def), .hsync(hsync_def), .vsync(vsync_def),
        .de(de_def), .x(x_def), .y(y_def), .sof(sof_def), .eol(eol_def)
    );

    vga_timing #(
        .CLKDIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_sml (
        .clk(clk), .rst(rst), .pxen(pxen_sml), .hsync(hsync_sml), .vsync(vsync_sml),
        .de(de_sml), .x(x_sml), .y(y_sml), .sof(sof_sml), .eol(eol_sml)
    );

    vga_timing #(
        .CLKDIV(4), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_med (
        .clk(clk), .rst(rst), .pxen(pxen_med), .hsync(hsync_med), .vsync(vsync_med),
        .de(de_med), .x(x_med), .y(y_med), .sof(sof_med), .eol(eol_med)
    );

    logic [27:0] obs_def, obs_sml, obs_med;
    assign obs_def = {pxen_def, hsync_def, vsync_def, de_def, sof_def, eol_def, x_def, y_def};
    assign obs_sml = {pxen_sml, hsync_sml, vsync_sml, de_sml, sof_sml, eol_sml, x_sml, y_sml};
    assign obs_med = {pxen_med, hsync_med, vsync_med, de_med, sof_med, eol_med, x_med, y_med};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs k clks after reset release, derived from pixel index.
    function automatic logic [27:0] model(input int d, input int ha, input int hf, input int hsw,
                                          input int hb, input int va, input int vf, input int vsw,
                                          input int vb, input logic hp, input logic vp, input int k);
        int   ht, vt, p, ph, h, v;
        logic pe, hs, vs, de, so, eo;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        p  = k / d;
        ph = k % d;
        h  = p % ht;
        v  = (p / ht) % vt;
        pe = (ph == d - 1);
        so = (ph == 0) && (h == 0) && (v == 0);
        eo = (ph == 0) && (h == ht - 1);
        de = (h < ha) && (v < va);
        hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hp : ~hp;
        vs = ((v >= va + vf) && (v < va + vf + vsw)) ? vp : ~vp;
        return {pe, hs, vs, de, so, eo, 11'(h), 11'(v)};
    endfunction

    function automatic logic [27:0] reset_vec(input logic hp, input logic vp);
        return {1'b0, ~hp, ~vp, 3'b000, 22'd0};
    endfunction

    logic [27:0] q_def[$];
    logic [27:0] q_sml[$];
    logic [27:0] q_med[$];
    int k_q = 0;

    always @(posedge clk) begin
        if (rst) begin
            q_def.push_back(reset_vec(1'b0, 1'b0));
            q_sml.push_back(reset_vec(1'b1, 1'b1));
            q_med.push_back(reset_vec(1'b0, 1'b0));
            k_q <= 0;
        end else begin
            q_def.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, k_q));
            q_sml.push_back(model(1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, k_q));
            q_med.push_back(model(4, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, k_q));
            k_q <= k_q + 1;
        end
    end

    int cyc = 0;
    int hs_run = 0, hs_len = -1, hs_x0 = -1;
    int shs_run = 0, shs_len = -1, shs_x0 = -1;
    int svs_run = 0, svs_len = -1, svs_y0 = -1;
    int mvs_run = 0, mvs_len = -1, mvs_y0 = -1;
    int eol_last = -1, eol_per = -1, eol_x = -1, eol_y = -1;
    int ssof_last = -1, ssof_per = -1;
    int msof_last = -1, msof_per = -1;
    int defall_x = -1, ymax_med = 0;
    logic de_prev = 1'b0;

    always @(negedge clk) begin
        if (q_def.size() != 0) check_val("sb_def", 32'(obs_def), 32'(q_def.pop_front()));
        if (q_sml.size() != 0) check_val("sb_sml", 32'(obs_sml), 32'(q_sml.pop_front()));
        if (q_med.size() != 0) check_val("sb_med", 32'(obs_med), 32'(q_med.pop_front()));
        cyc <= cyc + 1;

        if (!hsync_def) begin
            hs_run <= hs_run + 1;
            if (hs_run == 0) hs_x0 <= int'(x_def);
        end else if (hs_run != 0) begin
            if (hs_len < 0) hs_len <= hs_run;
            hs_run <= 0;
        end
        if (hsync_sml) begin
            shs_run <= shs_run + 1;
            if (shs_run == 0) shs_x0 <= int'(x_sml);
        end else if (shs_run != 0) begin
            if (shs_len < 0) shs_len <= shs_run;
            shs_run <= 0;
        end
        if (vsync_sml) begin
            svs_run <= svs_run + 1;
            if (svs_run == 0) svs_y0 <= int'(y_sml);
        end else if (svs_run != 0) begin
            if (svs_len < 0) svs_len <= svs_run;
            svs_run <= 0;
        end
        if (!vsync_med) begin
            mvs_run <= mvs_run + 1;
            if (mvs_run == 0) mvs_y0 <= int'(y_med);
        end else if (mvs_run != 0) begin
            if (mvs_len < 0) mvs_len <= mvs_run;
            mvs_run <= 0;
        end

        if (eol_def) begin
            if (eol_last >= 0 && eol_per < 0) eol_per <= cyc - eol_last;
            if (eol_x < 0) begin
                eol_x <= int'(x_def);
                eol_y <= int'(y_def);
            end
            eol_last <= cyc;
        end
        if (sof_sml) begin
            if (ssof_last >= 0 && ssof_per < 0) ssof_per <= cyc - ssof_last;
            ssof_last <= cyc;
        end
        if (sof_med) begin
            if (msof_last >= 0 && msof_per < 0) msof_per <= cyc - msof_last;
            msof_last <= cyc;
        end
        de_prev <= de_def;
        if (de_prev && !de_def && defall_x < 0) defall_x <= int'(x_def);
        if (int'(y_med) > ymax_med) ymax_med <= int'(y_med);
    end

    initial begin
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_def_outputs", 32'(obs_def), 32'(reset_vec(1'b0, 1'b0)));
        check_val("rst_sml_hsync_idle", 32'(hsync_sml), 32'd0);
        check_val("rst_sml_vsync_idle", 32'(vsync_sml), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7601; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_val("first_x", 32'(x_def), 32'd0);
                check_val("first_y", 32'(y_def), 32'd0);
                check_val("first_de", 32'(de_def), 32'd1);
                check_val("first_sof", 32'(sof_def), 32'd1);
                check_val("first_hs_vs", 32'({hsync_def, vsync_def}), 32'd3);
                check_val("sml_pxen", 32'(pxen_sml), 32'd1);
            end
            if (i < 4) check_val("pxen_first", 32'(pxen_def), 32'(i == 3));
        end

        check_val("pos_x300", 32'(x_def), 32'd300);
        check_val("pos_y2", 32'(y_def), 32'd2);
        check_val("de_fall_x", 32'(defall_x), 32'd640);
        check_val("hsync_len_clk", 32'(hs_len), 32'd384);
        check_val("hsync_start_x", 32'(hs_x0), 32'd656);
        check_val("eol_x", 32'(eol_x), 32'd799);
        check_val("eol_y", 32'(eol_y), 32'd0);
        check_val("line_period", 32'(eol_per), 32'd3200);
        check_val("sml_hsync_len", 32'(shs_len), 32'd2);
        check_val("sml_hsync_x", 32'(shs_x0), 32'd9);
        check_val("sml_vsync_len", 32'(svs_len), 32'd12);
        check_val("sml_vsync_y", 32'(svs_y0), 32'd5);
        check_val("sml_frame", 32'(ssof_per), 32'd84);
        check_val("med_vsync_len", 32'(mvs_len), 32'd48);
        check_val("med_vsync_y", 32'(mvs_y0), 32'd5);
        check_val("med_frame", 32'(msof_per), 32'd336);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("midrst_def", 32'(obs_def), 32'(reset_vec(1'b0, 1'b0)));
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("restart_xy", 32'({x_def, y_def}), 32'd0);
        check_val("restart_sof", 32'(sof_def), 32'd1);
        check_val("restart_de", 32'(de_def), 32'd1);
        check_val("restart_med_sof", 32'(sof_med), 32'd1);

        repeat (700) @(negedge clk);
        check_val("med_ymax", 32'(ymax_med), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator directly downstream of the pixel PLL. Runs on the PLL's 100 MHz `clkout` and derives a pixel-rate enable with an internal prescaler. Maintains horizontal and vertical position counters. Emits registered hsync, vsync, data-enable, pixel coordinates and frame/line markers for the pattern generators. Defaults give 640x480 at about 59.5 Hz, with a 25 MHz pixel rate from 100 MHz / 4.

## Interface
Parameters:
- CLKDIV, 4: clk cycles per pixel (≥1)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vsync width (lines)
- V_BP, 33: vertical back porch (lines)
- HS_POL, 0: hsync active level
- VS_POL, 0: vsync active level

Ports:
- clk  in  1  pixel-domain clock (PLL `clkout`); the only clock
- rst  in  1  synchronous, active-high reset
- pxen  out  1  one-clk pixel strobe, every CLKDIV clks
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high while position is in the active area
- x  out  11  horizontal counter value (0..H_TOTAL-1)
- y  out  11  vertical counter value (0..V_TOTAL-1)
- sof  out  1  one-clk pulse at start of pixel (0,0)
- eol  out  1  one-clk pulse at start of last pixel of each line

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Region order per line and per frame: active, front porch, sync, back porch.

Prescaler:
- `div` counts 0..CLKDIV-1 and wraps.
- Internal strobe `tick` is asserted when div == CLKDIV-1.
- When CLKDIV == 1, `tick` is constantly 1.

Counters, updated only on `tick`:
- hcnt increments; at H_TOTAL-1 it wraps to 0.
- vcnt increments only when hcnt wraps; at V_TOTAL-1 (with hcnt at H_TOTAL-1) it wraps to 0.
- Horizontal and vertical wrap in the same tick is the normal end-of-frame event: both counters become 0.

Output decode, all outputs registered from (hcnt, vcnt):
- de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- hsync is active for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines including porches.
- x = hcnt, y = vcnt, unmasked. Consumers gate with `de`.

Pulses:
- sof fires in the first clk that outputs show (0,0).
- eol fires in the first clk that x = H_TOTAL-1.
- Both are single-clk regardless of CLKDIV.

Reset:
- While rst is high: div, hcnt, vcnt = 0; de = 0; hsync = !HS_POL; vsync = !VS_POL; x = y = 0; sof = eol = pxen = 0.
- Asserting rst mid-frame aborts the frame. No partial-state preservation.

## Timing
- Counter advance occurs on the clk edge where tick = 1.
- Registered outputs reflect the new position one clk later, and hold it for CLKDIV clks.
- pxen is the registered tick. It pulses in the last clk of each output pixel, so consumers sample pixel data on pxen.
- First clk after rst deasserts: outputs show (0,0) with de = 1 and sof = 1.
- Line period: H_TOTAL*CLKDIV = 3200 clk.
- Frame period: 1,680,000 clk, i.e. 16.8 ms at 100 MHz.
- Widths: 11-bit counters cover totals up to 2047. Parameter totals over 2047 are unsupported; guard with an elaboration-time check.

## Structure
- Shared package `vga_pkg` holds:
  - 640x480 default timing constants
  - H_TOTAL/V_TOTAL functions
  - coordinate width constant (11)
- Natural sub-module `pix_prescaler`: holds div, produces tick, parameter CLKDIV.
- The remaining logic (counters plus registered decode) stays in `vga_timing`.

## Test plan
- Reset release, defaults → first clk: x=0, y=0, de=1, sof=1. pxen first pulses 4 clks after release. hsync=vsync=1 (inactive).
- Horizontal timing → de falls when x=640. hsync low for exactly 96 pixels (384 clk), starting at x=656. eol at x=799, then x=0, y=1.
- Vertical timing → vsync low for lines 490–491 (6400 clk). de=0 for y≥480. sof period exactly 1,680,000 clk.
- Frame wrap → at x=799, y=524 the next pixel is (0,0). sof=1 and the line counter does not glitch to 525.
- CLKDIV=1, small geometry (H 8/1/2/1, V 4/1/1/1) → pxen constant 1; line = 12 clk; frame = 84 clk. Polarity parameters set to 1 invert the idle levels.
- rst pulse at x=300, y=200 for 3 clk → outputs at reset values during reset; restart at (0,0) with sof=1 the clk after release.
